// File: rtl/uart_tx_buffer.sv
`default_nettype none
// uart_tx_buffer: byte FIFO between the CPU io write path and a UART transmitter (start/busy handshake).
// Optional feature macro UART_TX_BUF_LEVEL_EN exposes the fill count on port level.
module uart_tx_buffer #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic          tx_start,
  output logic [7:0]    tx_data,
`ifdef UART_TX_BUF_LEVEL_EN
  output logic [AW:0]   level,
`endif
  input  logic          tx_busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_HI = 2'd1;
  localparam logic [1:0] S_WAIT_LO = 2'd2;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  // Flags come from the registered count only, so wr_en never reaches them combinationally.
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign push  = wr_en && !full;

`ifdef UART_TX_BUF_LEVEL_EN
  assign level = count;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (!empty && !tx_busy) state_nxt = S_WAIT_HI;
      S_WAIT_HI: if (tx_busy)            state_nxt = S_WAIT_LO;
      S_WAIT_LO: if (!tx_busy)           state_nxt = S_IDLE;
      default:                           state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pop = 1'b0;
    if (state == S_IDLE) pop = !empty && !tx_busy;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // tx_start is registered alongside tx_data so the byte is valid in the pulse cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= pop;
      if (pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A dropped write outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset)              overflow <= 1'b0;
    else if (wr_en && full) overflow <= 1'b1;
    else if (ovf_clr)       overflow <= 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
`default_nettype none
// tb_uart_tx_buffer: randomized scoreboard bench with a behavioural transmitter and queue model.
module tb_uart_tx_buffer;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, wr_en = 1'b0, ovf_clr = 1'b0, hold = 1'b0, xbusy = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, tx_start, tx_busy;
  logic [7:0] tx_data;
`ifdef UART_TX_BUF_LEVEL_EN
  logic [4:0] level;
`endif

  assign tx_busy = xbusy | hold;

  uart_tx_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .overflow(overflow), .ovf_clr(ovf_clr),
    .tx_start(tx_start), .tx_data(tx_data),
`ifdef UART_TX_BUF_LEVEL_EN
    .level(level),
`endif
    .tx_busy(tx_busy)
  );

  int errors = 0, checks = 0, nstarts = 0, bcnt = 0;
  logic [7:0] q[$];
  bit   m_ovf = 0, waiting = 0, seen_hi = 0;
  logic [7:0] last_data = 8'h00;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transmitter model: busy rises one cycle after tx_start and stays high for a random frame.
  always @(posedge clk) begin
    logic st;
    st = tx_start;
    #1;
    if (st) begin
      xbusy = 1'b1;
      bcnt  = $urandom_range(2, 8);
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) xbusy = 1'b0;
    end
  end

  // Monitor and reference model: queue of accepted bytes, popped whenever the DUT starts a transfer.
  always @(posedge clk) begin
    logic s_rst, s_we, s_oc, s_busy;
    logic [7:0] s_wd, exp_b;
    bit full_pre;
    s_rst = reset; s_we = wr_en; s_oc = ovf_clr; s_busy = tx_busy; s_wd = wr_data;
    #2;
    if (s_rst) begin
      q.delete();
      m_ovf = 0; waiting = 0; seen_hi = 0; last_data = 8'h00;
      chk("rst_tx_start", int'(tx_start), 0);
      chk("rst_tx_data", int'(tx_data), 0);
    end else begin
      full_pre = (q.size() == DEPTH);
      if (tx_start) begin
        nstarts++;
        chk("start_busy_low", int'(s_busy), 0);
        chk("start_after_busy_fall", int'(waiting), 0);
        chk("start_nonempty", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          exp_b = q.pop_front();
          chk("tx_data", int'(tx_data), int'(exp_b));
        end
        last_data = tx_data;
        waiting = 1; seen_hi = 0;
      end else begin
        chk("tx_data_stable", int'(tx_data), int'(last_data));
        if (s_busy && waiting) seen_hi = 1;
        if (!s_busy && seen_hi) begin waiting = 0; seen_hi = 0; end
      end
      if (s_we && !full_pre) q.push_back(s_wd);
      if (s_we && full_pre)  m_ovf = 1;
      else if (s_oc)         m_ovf = 0;
    end
    chk("full", int'(full), int'(q.size() == DEPTH));
    chk("empty", int'(empty), int'(q.size() == 0));
    chk("overflow", int'(overflow), int'(m_ovf));
`ifdef UART_TX_BUF_LEVEL_EN
    chk("level", int'(level), q.size());
`endif
  end

  task automatic burst(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = first + 8'(i);
    end
    @(negedge clk); wr_en = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!(q.size() == 0 && empty && !tx_busy && bcnt == 0 && !tx_start) && n < budget) begin
      @(negedge clk); n++;
    end
    chk("drain_timeout", int'(n < budget), 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n0, n;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    n0 = nstarts;
    repeat (20) @(negedge clk);
    chk("idle_starts", nstarts - n0, 0);
    chk("idle_empty", int'(empty), 1);
    chk("idle_full", int'(full), 0);
    chk("idle_tx_data", int'(tx_data), 0);
    chk("idle_overflow", int'(overflow), 0);

    // Single byte with latency check
    n0 = nstarts;
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h5A;
    @(posedge clk);
    @(negedge clk); wr_en = 1'b0;
    @(posedge clk); #3;
    chk("latency_start", int'(tx_start), 1);
    chk("latency_data", int'(tx_data), 8'h5A);
    drain(200);
    chk("single_starts", nstarts - n0, 1);
    chk("single_empty", int'(empty), 1);

    // Burst ordering while the transmitter is held busy
    n0 = nstarts;
    @(negedge clk); hold = 1'b1;
    burst(5, 8'h01);
    chk("burst_held_starts", nstarts - n0, 0);
`ifdef UART_TX_BUF_LEVEL_EN
    chk("burst_level", int'(level), 5);
`endif
    @(negedge clk); hold = 1'b0;
    drain(400);
    chk("burst_starts", nstarts - n0, 5);

    // Full and overflow
    n0 = nstarts;
    @(negedge clk); hold = 1'b1;
    burst(DEPTH + 2, 8'h10);
    chk("ovf_full", int'(full), 1);
    chk("ovf_flag", int'(overflow), 1);
`ifdef UART_TX_BUF_LEVEL_EN
    chk("ovf_level", int'(level), DEPTH);
`endif
    @(negedge clk); hold = 1'b0;
    drain(1000);
    chk("ovf_starts", nstarts - n0, DEPTH);
    chk("ovf_sticky", int'(overflow), 1);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    chk("ovf_cleared", int'(overflow), 0);

    // 40 incrementing bytes with random gaps, crossing pointer wrap
    n0 = nstarts;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = 8'h40 + 8'(i);
      @(negedge clk); wr_en = 1'b0;
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    drain(2000);
    chk("stream_starts", nstarts - n0, 40);

    // Random traffic with occasional clears and held-busy stretches
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      wr_en   = ($urandom_range(0, 1) == 0);
      wr_data = 8'($urandom);
      ovf_clr = ($urandom_range(0, 15) == 0);
      hold    = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk); wr_en = 1'b0; ovf_clr = 1'b0; hold = 1'b0;
    drain(3000);

    // Reset while in WAIT_LO
    burst(3, 8'hA0);
    n = 0;
    while (!(tx_busy && !tx_start) && n < 100) begin @(negedge clk); n++; end
    chk("mid_wait_busy", int'(n < 100), 1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    n0 = nstarts;
    repeat (40) @(negedge clk);
    chk("mid_rst_starts", nstarts - n0, 0);
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_overflow", int'(overflow), 0);
    chk("final_queue", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
